// File: rtl/alu_pkg.sv
// alu_pkg: opcode/state types and the single-cycle ALU evaluation shared by RTL and models
package alu_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SHR = 3'b011,
        OP_SHL = 3'b100,
        OP_MUL = 3'b101,
        OP_SUB = 3'b110,
        OP_SRA = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } alu_state_t;

    typedef struct packed {
        logic [MAX_W-1:0] res;
        logic             n;
        logic             z;
        logic             c;
        logic             v;
    } alu_res_t;

    // Operands arrive zero-extended to MAX_W; w is the live width (power of two, <= MAX_W).
    // MUL yields zero here because the product comes from the iterative multiplier.
    function automatic alu_res_t alu_eval(input alu_op_t op, input logic [MAX_W-1:0] a,
                                          input logic [MAX_W-1:0] b, input int w);
        logic [MAX_W-1:0]        mask, res, t, ax;
        logic signed [MAX_W-1:0] sx;
        logic [MAX_W:0]          s, u;
        logic                    am, bm, rm, c, v;
        int                      sh;
        mask = (w >= MAX_W) ? '1 : (64'd1 << w) - 64'd1;
        sh   = int'(b[5:0]) & (w - 1);
        t    = a >> (w - 1);
        am   = t[0];
        t    = b >> (w - 1);
        bm   = t[0];
        ax   = a | (am ? ~mask : '0);
        res  = '0;
        c    = 1'b0;
        case (op)
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_ADD: begin
                s   = {1'b0, a} + {1'b0, b};
                res = s[MAX_W-1:0] & mask;
                u   = s >> w;
                c   = u[0];
            end
            OP_SUB: begin
                s   = {1'b0, a} - {1'b0, b};
                res = s[MAX_W-1:0] & mask;
                c   = a >= b;
            end
            OP_SHR: begin
                res = a >> sh;
                t   = a >> (sh - 1);
                c   = (sh != 0) && t[0];
            end
            OP_SHL: begin
                res = (a << sh) & mask;
                t   = a >> (w - sh);
                c   = (sh != 0) && t[0];
            end
            OP_SRA: begin
                sx  = ax;
                sx  = sx >>> sh;
                res = sx & mask;
                t   = a >> (sh - 1);
                c   = (sh != 0) && t[0];
            end
            default: res = '0;
        endcase
        t  = res >> (w - 1);
        rm = t[0];
        v  = (op == OP_ADD) ? (am == bm) && (rm != am) :
             (op == OP_SUB) ? (am != bm) && (rm != am) : 1'b0;
        return {res, rm, res == '0, c, v};
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: radix-2 shift-add multiplier, one multiplier bit per cycle over WIDTH cycles
module alu_mul_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_acc_next;

    // The final partial product is folded in combinationally so the product is ready on the done cycle.
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign done       = r_busy && (r_cnt == CNT_W'(WIDTH - 1));
    assign product    = w_acc_next;

    // Load operands on start, then accumulate and shift once per cycle until the last bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_mcand  <= a;
            r_mplier <= b;
            r_acc    <= '0;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            r_busy   <= !done;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with registered result/NZCV behind a valid/ready handshake
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_t          alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             n,
    output logic             z,
    output logic             c,
    output logic             v
);

    alu_state_t       r_state;
    logic             r_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_n, r_z, r_c, r_v;
    logic             w_accept;
    logic             w_start;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_product;
    alu_res_t         w_eval;

    assign in_ready  = rst_n && (r_state == IDLE || (r_state == DONE && out_ready));
    assign w_accept  = in_valid && in_ready;
    assign w_start   = w_accept && (alu_op == OP_MUL);
    assign w_eval    = alu_eval(alu_op, MAX_W'(a), MAX_W'(b), WIDTH);
    assign out_valid = r_valid;
    assign result    = r_result;
    assign {n, z, c, v} = {r_n, r_z, r_c, r_v};

    alu_mul_iter #(
        .WIDTH (WIDTH),
        .CNT_W (SHAMT_W)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_start),
        .a       (a),
        .b       (b),
        .done    (w_mul_done),
        .product (w_product)
    );

    // Control FSM: an accept in DONE retires the old result and loads the new op on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_valid  <= 1'b0;
            r_result <= '0;
            {r_n, r_z, r_c, r_v} <= '0;
        end else if (w_accept) begin
            r_state <= (alu_op == OP_MUL) ? MUL : DONE;
            r_valid <= alu_op != OP_MUL;
            if (alu_op != OP_MUL) begin
                r_result <= WIDTH'(w_eval.res);
                {r_n, r_z, r_c, r_v} <= {w_eval.n, w_eval.z, w_eval.c, w_eval.v};
            end
        end else if (r_state == MUL && w_mul_done) begin
            r_state  <= DONE;
            r_valid  <= 1'b1;
            r_result <= w_product;
            {r_n, r_z, r_c, r_v} <= {w_product[WIDTH-1], w_product == '0, 2'b00};
        end else if (r_state == DONE && out_ready) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench for alu_mc with directed, backpressure, reset and random cases
module tb_alu_mc;
    import alu_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [35:0] exp;
        int          cyc;
        int          lat;
    } sb_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic         in_ready, out_valid, n, z, c, v;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] result;
    alu_op_t      alu_op = OP_AND;
    sb_t          q[$];
    int           cyc = 0;
    int           n_chk = 0;
    int           n_err = 0;
    int           acc0, acc1, rel, hi;
    bit           mon_en = 1'b0;
    bit           seen = 1'b0;

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .alu_op    (alu_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .n         (n),
        .z         (z),
        .c         (c),
        .v         (v)
    );

    always #5 clk = ~clk;

    // Edge counter used to measure accept-to-valid latency.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [35:0] model(input alu_op_t op, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
        logic [32:0] s;
        logic        cr, vr;
        int          sh;
        sh = int'(y[4:0]);
        cr = 1'b0;
        vr = 1'b0;
        case (op)
            OP_AND: r = x & y;
            OP_OR:  r = x | y;
            OP_ADD: begin
                s  = {1'b0, x} + {1'b0, y};
                r  = s[31:0];
                cr = s[32];
                vr = (x[31] == y[31]) && (r[31] != x[31]);
            end
            OP_SUB: begin
                r  = x - y;
                cr = x >= y;
                vr = (x[31] != y[31]) && (r[31] != x[31]);
            end
            OP_SHR: begin
                r  = x >> sh;
                cr = (sh != 0) ? x[sh-1] : 1'b0;
            end
            OP_SHL: begin
                r  = x << sh;
                cr = (sh != 0) ? x[32-sh] : 1'b0;
            end
            OP_SRA: begin
                r  = $signed(x) >>> sh;
                cr = (sh != 0) ? x[sh-1] : 1'b0;
            end
            default: r = x * y;
        endcase
        return {r, r[31], r == 32'd0, cr, vr};
    endfunction

    task automatic issue(input alu_op_t op, input logic [31:0] xa, input logic [31:0] xb,
                         input logic [35:0] exp, output int acc);
        bit ok;
        ok = 1'b0;
        acc = -1;
        alu_op = op;
        a = xa;
        b = xb;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (ok) begin
            acc = cyc;
            q.push_back('{exp, cyc, (op == OP_MUL) ? W : 0});
        end else begin
            chk("accept_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    // Output monitor: latency on first valid, data on handshake, nothing valid when nothing is owed.
    always @(negedge clk) begin
        if (mon_en) begin
            if (q.size() == 0) begin
                chk("spurious_valid", 32'(out_valid), 32'd0);
            end else if (out_valid) begin
                if (!seen) begin
                    chk("latency", 32'(cyc - q[0].cyc), 32'(q[0].lat));
                    seen = 1'b1;
                end
                if (out_ready) begin
                    chk("result", result, q[0].exp[35:4]);
                    chk("flags", 32'({n, z, c, v}), 32'(q[0].exp[3:0]));
                    void'(q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", 32'({n, z, c, v}), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        mon_en = 1'b1;

        issue(OP_ADD, 32'h7FFFFFFF, 32'h00000001, {32'h80000000, 4'b1001}, acc0);
        issue(OP_SUB, 32'd5, 32'd5, {32'h00000000, 4'b0110}, acc1);
        chk("b2b_accept", 32'(acc1 - acc0), 32'd1);
        issue(OP_SUB, 32'd3, 32'd5, {32'hFFFFFFFE, 4'b1000}, acc0);
        issue(OP_SHL, 32'h80000001, 32'h00000021, {32'h00000002, 4'b0010}, acc0);
        issue(OP_SRA, 32'h80000000, 32'd4, {32'hF8000000, 4'b1000}, acc0);
        issue(OP_SHR, 32'h80000000, 32'd0, {32'h80000000, 4'b1000}, acc0);
        issue(OP_AND, 32'hFFFF0000, 32'h0F0F0F0F, {32'h0F0F0000, 4'b0000}, acc0);
        issue(OP_OR, 32'd0, 32'd0, {32'h00000000, 4'b0100}, acc0);

        issue(OP_MUL, 32'd7, 32'd6, {32'd42, 4'b0000}, acc0);
        hi = 0;
        repeat (31) begin
            @(negedge clk);
            if (in_ready) hi++;
        end
        chk("mul_in_ready", 32'(hi), 32'd0);
        @(posedge clk);
        #1;
        issue(OP_MUL, 32'h00010000, 32'h00010000, {32'h00000000, 4'b0100}, acc0);
        drain();

        out_ready = 1'b0;
        issue(OP_ADD, 32'h10, 32'h20, {32'h00000030, 4'b0000}, acc0);
        repeat (3) begin
            @(negedge clk);
            chk("bp_result", result, 32'h30);
            chk("bp_flags", 32'({n, z, c, v}), 32'd0);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        rel = cyc;
        issue(OP_SUB, 32'h10, 32'h20, {32'hFFFFFFF0, 4'b1000}, acc1);
        chk("bp_no_bubble", 32'(acc1 - rel), 32'd1);

        for (int i = 0; i < 24; i++) begin
            alu_op_t     op;
            logic [31:0] xa, xb;
            op = alu_op_t'(3'($urandom_range(0, 7)));
            xa = $urandom;
            xb = ($urandom_range(0, 3) == 0) ? xa : $urandom;
            issue(op, xa, xb, model(op, xa, xb), acc0);
        end
        drain();

        issue(OP_MUL, 32'h1234, 32'h5678, model(OP_MUL, 32'h1234, 32'h5678), acc0);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        q.delete();
        seen = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_flags", 32'({n, z, c, v}), 32'd0);
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rel_in_ready", 32'(in_ready), 32'd1);
        repeat (25) @(posedge clk);
        #1;
        issue(OP_ADD, 32'h7FFFFFFF, 32'h7FFFFFFF, {32'hFFFFFFFE, 4'b1001}, acc0);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
